page_arbiter: RTL and testbench

Owns the shared seven-segment display and the four-button pad on behalf of the feature pages: home clock page, settings and timer pages, plus a high-priority alert source. Grants exactly one page ownership at a time. Forwards button edges only to the owner and muxes the owner's 32-bit display word to the tube driver. Sits between the button edge detector and the display driver, above the individual page modules.

---
 rtl/arb_pkg.sv | 15 +
 rtl/sec_tick_gen.sv | 30 +++
 rtl/page_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_page_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared constants for the page arbiter: FSM encoding, button codes and the home page index.
package arb_pkg;

    localparam logic [1:0] ST_HOME  = 2'd0;
    localparam logic [1:0] ST_OWNED = 2'd1;
    localparam logic [1:0] ST_ALERT = 2'd2;

    localparam logic [3:0] BTN_UP    = 4'b0001;
    localparam logic [3:0] BTN_LEFT  = 4'b0010;
    localparam logic [3:0] BTN_RIGHT = 4'b0100;
    localparam logic [3:0] BTN_DOWN  = 4'b1000;

    localparam int PAGE_HOME = 0;

endpackage

// File: rtl/sec_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every TICK_DIV clock cycles.
module sec_tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CW'(TICK_DIV - 1)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/page_arbiter.sv
// Display/button ownership arbiter between feature pages and the alert source.
// Optional idle-return-to-home timeout is enabled by defining ARB_IDLE_TIMEOUT_EN.
module page_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TICK_DIV       = 100_000_000,
    parameter int IDLE_SEC       = 10,
    parameter int ALERT_HOLD_SEC = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [N_REQ-1:0]      i_release,
    input  logic                  i_alert_req,
    input  logic [31:0]           i_alert_data,
    input  logic [3:0]            i_btn_edge,
    input  logic [32*N_REQ-1:0]   i_page_data,
    output logic [N_REQ-1:0]      o_grant,
    output logic                  o_alert_active,
    output logic [4*N_REQ-1:0]    o_btn_out,
    output logic [31:0]           o_time_data_out,
    output logic [1:0]            o_dbg_state
);

    localparam int OW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HOLD_W = $clog2(ALERT_HOLD_SEC + 1);

    logic [1:0]          r_state;
    logic [1:0]          r_ret_state;
    logic [OW-1:0]       r_owner;
    logic [OW-1:0]       r_ret_owner;
    logic [OW-1:0]       r_last_owner;
    logic [N_REQ-1:0]    r_grant;
    logic                r_alert_active;
    logic [4*N_REQ-1:0]  r_btn_out;
    logic [31:0]         r_time_data;
    logic [HOLD_W-1:0]   r_hold_cnt;

    logic                w_tick;
    logic                w_timeout;
    logic                w_owner_rel;
    logic                w_rr_found;
    logic [OW-1:0]       w_rr_pick;
    logic [1:0]          w_state_next;
    logic [1:0]          w_ret_state_next;
    logic [OW-1:0]       w_owner_next;
    logic [OW-1:0]       w_ret_owner_next;
    logic [OW-1:0]       w_last_owner_next;
    logic [N_REQ-1:0]    w_grant_next;
    logic [4*N_REQ-1:0]  w_btn_next;

    sec_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

`ifdef ARB_IDLE_TIMEOUT_EN
    localparam int IDLE_W = $clog2(IDLE_SEC + 1);
    logic [IDLE_W-1:0] r_idle_cnt;

    // Any button activity or leaving OWNED restarts the idle window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idle_cnt <= '0;
        end else if (r_state != ST_OWNED || w_state_next != ST_OWNED || i_btn_edge != 4'b0000) begin
            r_idle_cnt <= '0;
        end else if (w_tick && r_idle_cnt != IDLE_W'(IDLE_SEC)) begin
            r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
        end
    end

    assign w_timeout = (r_idle_cnt == IDLE_W'(IDLE_SEC));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_owner_rel = i_release[r_owner];

    // Round-robin search starting after the last owner, wrapping over pages 1..N_REQ-1.
    always_comb begin
        int v_cand;
        v_cand     = 0;
        w_rr_found = 1'b0;
        w_rr_pick  = '0;
        for (int i = 1; i < N_REQ; i++) begin
            v_cand = int'(r_last_owner) + i;
            if (v_cand >= N_REQ) v_cand = v_cand - (N_REQ - 1);
            if (!w_rr_found && i_req[v_cand]) begin
                w_rr_found = 1'b1;
                w_rr_pick  = OW'(v_cand);
            end
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_ret_state_next  = r_ret_state;
        w_owner_next      = r_owner;
        w_ret_owner_next  = r_ret_owner;
        w_last_owner_next = r_last_owner;
        case (r_state)
            ST_HOME: begin
                if (i_alert_req) begin
                    w_state_next     = ST_ALERT;
                    w_ret_state_next = ST_HOME;
                    w_ret_owner_next = OW'(PAGE_HOME);
                end else if (w_rr_found) begin
                    w_state_next      = ST_OWNED;
                    w_owner_next      = w_rr_pick;
                    w_last_owner_next = w_rr_pick;
                end
            end
            ST_OWNED: begin
                if (i_alert_req) begin
                    w_state_next = ST_ALERT;
                    if (w_owner_rel || w_timeout) begin
                        w_ret_state_next = ST_HOME;
                        w_ret_owner_next = OW'(PAGE_HOME);
                    end else begin
                        w_ret_state_next = ST_OWNED;
                        w_ret_owner_next = r_owner;
                    end
                end else if (w_owner_rel || w_timeout) begin
                    w_state_next = ST_HOME;
                    w_owner_next = OW'(PAGE_HOME);
                end
            end
            ST_ALERT: begin
                if (!i_alert_req && r_hold_cnt == HOLD_W'(ALERT_HOLD_SEC)) begin
                    w_state_next = r_ret_state;
                    w_owner_next = r_ret_owner;
                end
            end
            default: begin
                w_state_next = ST_HOME;
                w_owner_next = OW'(PAGE_HOME);
            end
        endcase
    end

    // Buttons follow the post-update grant, so an all-zero grant (alert) drops them.
    always_comb begin
        w_grant_next = '0;
        if (w_state_next != ST_ALERT) w_grant_next[w_owner_next] = 1'b1;
        w_btn_next = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (w_grant_next[k]) w_btn_next[4*k +: 4] = i_btn_edge;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_HOME;
            r_ret_state    <= ST_HOME;
            r_owner        <= OW'(PAGE_HOME);
            r_ret_owner    <= OW'(PAGE_HOME);
            r_last_owner   <= OW'(PAGE_HOME);
            r_grant        <= N_REQ'(1);
            r_alert_active <= 1'b0;
            r_btn_out      <= '0;
            r_time_data    <= '0;
        end else begin
            r_state        <= w_state_next;
            r_ret_state    <= w_ret_state_next;
            r_owner        <= w_owner_next;
            r_ret_owner    <= w_ret_owner_next;
            r_last_owner   <= w_last_owner_next;
            r_grant        <= w_grant_next;
            r_alert_active <= (w_state_next == ST_ALERT);
            r_btn_out      <= w_btn_next;
            r_time_data    <= (r_state == ST_ALERT) ? i_alert_data : i_page_data[32*r_owner +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_cnt <= '0;
        end else if (r_state != ST_ALERT) begin
            r_hold_cnt <= '0;
        end else if (w_tick && r_hold_cnt != HOLD_W'(ALERT_HOLD_SEC)) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
    end

    assign o_grant         = r_grant;
    assign o_alert_active  = r_alert_active;
    assign o_btn_out       = r_btn_out;
    assign o_time_data_out = r_time_data;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_page_arbiter.sv
// Directed bench for page_arbiter: a per-cycle vector table plus hand-written alert/timeout/reset sequences.
module tb_page_arbiter;
    import arb_pkg::*;

    localparam int N_REQ = 4;

    localparam logic [31:0] PD0 = 32'hC10C_0000;
    localparam logic [31:0] PD1 = 32'h5E70_0001;
    localparam logic [31:0] PD2 = 32'h7173_0002;
    localparam logic [31:0] PD3 = 32'hBEEF_0003;
    localparam logic [31:0] ALD = 32'hA1E7_7777;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [N_REQ-1:0]     i_req = '0;
    logic [N_REQ-1:0]     i_release = '0;
    logic                 i_alert_req = 1'b0;
    logic [31:0]          i_alert_data = ALD;
    logic [3:0]           i_btn_edge = '0;
    logic [32*N_REQ-1:0]  i_page_data = {PD3, PD2, PD1, PD0};
    logic [N_REQ-1:0]     o_grant;
    logic                 o_alert_active;
    logic [4*N_REQ-1:0]   o_btn_out;
    logic [31:0]          o_time_data_out;
    logic [1:0]           o_dbg_state;

    page_arbiter #(
        .N_REQ(N_REQ), .TICK_DIV(10), .IDLE_SEC(3), .ALERT_HOLD_SEC(2)
    ) dut (
        .clk(clk), .rst(rst), .i_req(i_req), .i_release(i_release),
        .i_alert_req(i_alert_req), .i_alert_data(i_alert_data), .i_btn_edge(i_btn_edge),
        .i_page_data(i_page_data), .o_grant(o_grant), .o_alert_active(o_alert_active),
        .o_btn_out(o_btn_out), .o_time_data_out(o_time_data_out), .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  rel;
        logic [3:0]  btn;
        logic [3:0]  exp_grant;
        logic [15:0] exp_btn;
        logic [31:0] exp_time;
    } vec_t;

    vec_t vecs[9];

    task automatic wait_alert_drop(output int cyc, input int start);
        cyc = start;
        while (o_alert_active && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int n;

        // req, release, btn, expected grant, btn_out, time_data
        vecs[0] = '{4'b0000, 4'b0000, 4'b0000,   4'b0001, 16'h0000, PD0};
        vecs[1] = '{4'b0000, 4'b0000, BTN_RIGHT, 4'b0001, 16'h0004, PD0};
        vecs[2] = '{4'b0110, 4'b0000, 4'b0000,   4'b0010, 16'h0000, PD0};
        vecs[3] = '{4'b0110, 4'b0000, BTN_UP,    4'b0010, 16'h0010, PD1};
        vecs[4] = '{4'b0100, 4'b0010, BTN_RIGHT, 4'b0001, 16'h0004, PD1};
        vecs[5] = '{4'b0100, 4'b0000, BTN_LEFT,  4'b0100, 16'h0200, PD0};
        vecs[6] = '{4'b0100, 4'b0010, BTN_DOWN,  4'b0100, 16'h0800, PD2};
        vecs[7] = '{4'b0000, 4'b0100, 4'b0000,   4'b0001, 16'h0000, PD2};
        vecs[8] = '{4'b0000, 4'b0000, 4'b0000,   4'b0001, 16'h0000, PD0};

        repeat (3) @(negedge clk);
        check("reset grant", 32'(o_grant), 32'h1);
        check("reset alert_active", 32'(o_alert_active), 32'h0);
        check("reset btn_out", 32'(o_btn_out), 32'h0);
        check("reset time_data", o_time_data_out, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            i_req = vecs[i].req;
            i_release = vecs[i].rel;
            i_btn_edge = vecs[i].btn;
            @(negedge clk);
            check($sformatf("vec%0d grant", i), 32'(o_grant), 32'(vecs[i].exp_grant));
            check($sformatf("vec%0d btn_out", i), 32'(o_btn_out), 32'(vecs[i].exp_btn));
            check($sformatf("vec%0d time_data", i), o_time_data_out, vecs[i].exp_time);
        end
        i_req = '0; i_release = '0; i_btn_edge = '0;

        // Owner 2 left idle
        i_req = 4'b0100;
        @(negedge clk);
        check("idle owner grant", 32'(o_grant), 32'h4);
        i_req = '0;
`ifdef ARB_IDLE_TIMEOUT_EN
        n = 0;
        while (o_grant == 4'b0100 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("idle timeout grant", 32'(o_grant), 32'h1);
        check("idle timeout not early", 32'(n >= 18), 32'h1);
`else
        repeat (40) @(negedge clk);
        check("no idle timeout grant", 32'(o_grant), 32'h4);
`endif
        i_release = 4'b0100;
        @(negedge clk);
        i_release = '0;
        check("after idle grant", 32'(o_grant), 32'h1);

        // Alert over owner 1, returns to owner 1
        i_req = 4'b0010;
        @(negedge clk);
        check("alert pre grant", 32'(o_grant), 32'h2);
        i_req = '0;
        i_alert_req = 1'b1;
        @(negedge clk);
        check("alert active", 32'(o_alert_active), 32'h1);
        check("alert grant", 32'(o_grant), 32'h0);
        i_btn_edge = BTN_LEFT;
        @(negedge clk);
        i_btn_edge = '0;
        check("alert btn dropped", 32'(o_btn_out), 32'h0);
        check("alert time_data", o_time_data_out, ALD);
        repeat (3) @(negedge clk);
        check("alert held", 32'(o_alert_active), 32'h1);
        i_alert_req = 1'b0;
        wait_alert_drop(cyc, 4);
        check("alert exit", 32'(o_alert_active), 32'h0);
        check("alert hold length", 32'(cyc >= 11 && cyc <= 22), 32'h1);
        check("alert return grant", 32'(o_grant), 32'h2);
        @(negedge clk);
        check("alert return time_data", o_time_data_out, PD1);
        i_release = 4'b0010;
        @(negedge clk);
        i_release = '0;
        check("post alert release", 32'(o_grant), 32'h1);

        // Alert and owner release in the same cycle
        i_req = 4'b0010;
        @(negedge clk);
        check("alert+rel pre grant", 32'(o_grant), 32'h2);
        i_req = '0;
        i_alert_req = 1'b1;
        i_release = 4'b0010;
        @(negedge clk);
        i_release = '0;
        i_alert_req = 1'b0;
        check("alert+rel active", 32'(o_alert_active), 32'h1);
        wait_alert_drop(cyc, 0);
        check("alert+rel exit", 32'(o_alert_active), 32'h0);
        check("alert+rel return home", 32'(o_grant), 32'h1);

        // Reset in the middle of an alert
        i_alert_req = 1'b1;
        repeat (3) @(negedge clk);
        check("pre reset alert", 32'(o_alert_active), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("mid reset alert_active", 32'(o_alert_active), 32'h0);
        check("mid reset grant", 32'(o_grant), 32'h1);
        check("mid reset time_data", o_time_data_out, 32'h0);
        i_alert_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("after reset grant", 32'(o_grant), 32'h1);
        check("after reset alert_active", 32'(o_alert_active), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
